// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC width, return-stack depth and the call/return opcodes
// that the control unit decodes into push/pop.
package cpu_pkg;

  localparam int PC_W         = 10;
  localparam int RSTACK_DEPTH = 16;

  localparam logic [5:0] OP_PUSH = 6'b100100;
  localparam logic [5:0] OP_POP  = 6'b100101;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO beside the PC. The top entry is combinational so a pop
// hands its address to the next-PC mux in the same cycle the pointer drops.
module return_stack
  import cpu_pkg::*;
#(
  parameter int AW    = PC_W,
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [PW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [0:DEPTH-1];
  logic [PW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          we;
  logic [IW-1:0] waddr;
  logic [IW-1:0] top_idx;
  logic          is_empty, is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == PW'(DEPTH));
  assign top_idx  = IW'(sp_q - PW'(1));

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = IW'(sp_q);
    if (push && pop && !is_empty) begin
      // Replace the top in place: a return immediately followed by a call.
      we    = 1'b1;
      waddr = top_idx;
    end else if (push) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        we   = 1'b1;
        sp_d = sp_q + PW'(1);
      end
    end else if (pop) begin
      if (is_empty) unf_d = 1'b1;
      else          sp_d  = sp_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately not reset; the sp==0 gate on dout hides stale data.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= din;
  end

  assign dout      = is_empty ? '0 : mem_q[top_idx];
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed and random checks of return_stack against hand-computed values and a
// queue model of the stack.
module tb_return_stack;
  import cpu_pkg::*;

  localparam int AW    = PC_W;
  localparam int DEPTH = RSTACK_DEPTH;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop;
  logic [AW-1:0] din;
  logic [AW-1:0] dout;
  logic [PW-1:0] count;
  logic          empty, full, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q[$];
  logic          exp_ovf, exp_unf;

  return_stack dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .dout(dout), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Pulse reset between edges (called at posedge+1) and check the async clear.
  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #2;
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_flags"}, {30'd0, overflow, underflow}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic p, input logic q, input logic [AW-1:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic model_step(input logic p, input logic q, input logic [AW-1:0] d);
    if (p && q && exp_q.size() > 0) begin
      exp_q[exp_q.size()-1] = d;
    end else if (p) begin
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(d);
    end else if (q) begin
      if (exp_q.size() == 0) exp_unf = 1'b1;
      else void'(exp_q.pop_back());
    end
  endtask

  task automatic check_state(input string tag);
    logic [AW-1:0] top;
    top = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : '0;
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_dout"}, 32'(dout), 32'(top));
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] vals [3];
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    #2;
    check("por_count", 32'(count), 32'd0);
    check("por_empty", 32'(empty), 32'd1);
    check("por_full", 32'(full), 32'd0);
    check("por_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset mid-run with count=3 and underflow set
    cycle(1'b0, 1'b1, '0);
    check("t1_unf_set", 32'(underflow), 32'd1);
    cycle(1'b1, 1'b0, 10'h001);
    cycle(1'b1, 1'b0, 10'h002);
    cycle(1'b1, 1'b0, 10'h003);
    check("t1_count3", 32'(count), 32'd3);
    reset_pulse("t1_rst");

    // 2: LIFO order
    vals[0] = 10'h010; vals[1] = 10'h020; vals[2] = 10'h3FF;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vals[i]);
    check("t2_dout", 32'(dout), 32'h3FF);
    check("t2_count", 32'(count), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      pop = 1'b1;
      #1;
      check($sformatf("t2_pop%0d", i), 32'(dout), 32'(vals[i]));
      cycle(1'b0, 1'b1, '0);
    end
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_dout0", 32'(dout), 32'd0);

    // 3: full and overflow
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 10'(10'h100 + i));
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf_pre", 32'(overflow), 32'd0);
    cycle(1'b1, 1'b0, 10'h2AA);
    check("t3_count", 32'(count), 32'd16);
    check("t3_dout", 32'(dout), 32'h10F);
    check("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 15; i >= 0; i--) begin
      pop = 1'b1;
      #1;
      check($sformatf("t3_pop%0d", i), 32'(dout), 32'h100 + 32'(i));
      cycle(1'b0, 1'b1, '0);
    end
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: underflow
    reset_pulse("t4_rst");
    cycle(1'b0, 1'b1, '0);
    check("t4_count", 32'(count), 32'd0);
    check("t4_dout", 32'(dout), 32'd0);
    check("t4_unf", 32'(underflow), 32'd1);
    cycle(1'b1, 1'b0, 10'h055);
    check("t4_dout55", 32'(dout), 32'h055);
    check("t4_unf_sticky", 32'(underflow), 32'd1);

    // 5: simultaneous push & pop
    reset_pulse("t5_rst");
    cycle(1'b1, 1'b0, 10'h011);
    cycle(1'b1, 1'b0, 10'h022);
    cycle(1'b1, 1'b1, 10'h077);
    check("t5_count", 32'(count), 32'd2);
    check("t5_dout77", 32'(dout), 32'h077);
    cycle(1'b0, 1'b1, '0);
    check("t5_dout11", 32'(dout), 32'h011);
    cycle(1'b0, 1'b1, '0);
    check("t5_empty", 32'(empty), 32'd1);
    cycle(1'b1, 1'b1, 10'h0AA);
    check("t5_count1", 32'(count), 32'd1);
    check("t5_doutAA", 32'(dout), 32'h0AA);
    check("t5_unf", 32'(underflow), 32'd0);

    // 6: random traffic against the queue model
    reset_pulse("t6_rst0");
    for (int i = 0; i < 2000; i++) begin
      logic p, q;
      logic [AW-1:0] d;
      int bias;
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse($sformatf("t6_rst%0d", i));
      end else begin
        bias = ((i / 150) % 2 == 0) ? 75 : 25;
        p = ($urandom_range(0, 99) < bias);
        q = ($urandom_range(0, 99) < (100 - bias));
        d = AW'($urandom_range(0, (1 << AW) - 1));
        model_step(p, q, d);
        cycle(p, q, d);
        check_state($sformatf("t6_c%0d", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
